// File: rtl/mt32_pkg.sv
// rtl/mt32_pkg.sv - MT19937 constants, state encoding and seeding recurrence
package mt32_pkg;

    localparam logic [31:0] N          = 32'd624;
    localparam logic [31:0] M          = 32'd397;
    localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] INIT_MULT  = 32'd1812433253;

    localparam int          TEMPER_U = 11;
    localparam int          TEMPER_S = 7;
    localparam int          TEMPER_T = 15;
    localparam int          TEMPER_L = 18;
    localparam logic [31:0] TEMPER_B = 32'h9D2C_5680;
    localparam logic [31:0] TEMPER_C = 32'hEFC6_0000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PRIME,
        GEN_RD,
        GEN_WR
    } state_e;

    function automatic logic [31:0] init_step(input logic [31:0] prev, input logic [31:0] idx);
        return INIT_MULT * (prev ^ (prev >> 30)) + idx;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// rtl/dp_ram.sv - true dual-port RAM, read-first, one-cycle read latency
module dp_ram #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 10
) (
    input  logic               clk,
    input  logic               en0,
    input  logic               we0,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic [D_WIDTH-1:0] wdata0,
    output logic [D_WIDTH-1:0] rdata0,
    input  logic               en1,
    input  logic               we1,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic [D_WIDTH-1:0] rdata1
);

    logic [D_WIDTH-1:0] mem [2**A_WIDTH];
    logic [D_WIDTH-1:0] rdata0_q;
    logic [D_WIDTH-1:0] rdata1_q;

    always_ff @(posedge clk) begin
        if (en0) begin
            rdata0_q <= mem[addr0];
            if (we0) mem[addr0] <= wdata0;
        end
        if (en1) begin
            rdata1_q <= mem[addr1];
            if (we1) mem[addr1] <= wdata1;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: rtl/mt32_temper.sv
// rtl/mt32_temper.sv - combinational MT19937 output tempering
module mt32_temper
    import mt32_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] t3;

    always_comb begin
        t1   = din ^ (din >> TEMPER_U);
        t2   = t1 ^ ((t1 << TEMPER_S) & TEMPER_B);
        t3   = t2 ^ ((t2 << TEMPER_T) & TEMPER_C);
        dout = t3 ^ (t3 >> TEMPER_L);
    end

endmodule

// File: rtl/mt32_engine.sv
// rtl/mt32_engine.sv - MT19937 seeding and in-place generation over a dual-port state RAM
module mt32_engine
    import mt32_pkg::*;
#(
    parameter bit          AUTO_SEED = 1'b0,
    parameter logic [31:0] DEF_SEED  = 32'd5489,
    parameter int          A_WIDTH   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        seed_valid,
    output logic        busy,
    output logic        ready_gen,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] i_q, i_d;
    logic [31:0]        prev_q, prev_d;
    logic [31:0]        cur_q, cur_d;
    logic               prime_ph_q, prime_ph_d;
    logic               auto_q, auto_d;
    logic               busy_q, busy_d;
    logic               ready_gen_q, ready_gen_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;

    logic               en0, we0, en1;
    logic [A_WIDTH-1:0] addr0, addr1;
    logic [31:0]        wdata0, rdata0, rdata1;

    logic               start;
    logic [31:0]        start_val;
    logic [31:0]        init_val;
    logic [A_WIDTH-1:0] i_plus1;
    logic [31:0]        i_plus_m;
    logic [A_WIDTH-1:0] addr_m;
    logic [31:0]        y;
    logic [31:0]        new_word;
    logic [31:0]        tempered;

    dp_ram #(
        .D_WIDTH(32),
        .A_WIDTH(A_WIDTH)
    ) u_state_ram (
        .clk   (clk),
        .en0   (en0),
        .we0   (we0),
        .addr0 (addr0),
        .wdata0(wdata0),
        .rdata0(rdata0),
        .en1   (en1),
        .we1   (1'b0),
        .addr1 (addr1),
        .wdata1(32'd0),
        .rdata1(rdata1)
    );

    // cur_q holds mt[i] so that only mt[i+1] and mt[i+M] need fetching per word
    assign y        = (cur_q & UPPER_MASK) | (rdata0 & LOWER_MASK);
    assign new_word = rdata1 ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);

    mt32_temper u_temper (
        .din (new_word),
        .dout(tempered)
    );

    assign start     = seed_valid | auto_q;
    assign start_val = seed_valid ? seed : DEF_SEED;
    assign init_val  = (i_q == '0) ? prev_q : init_step(prev_q, 32'(i_q));
    assign i_plus1   = (32'(i_q) == N - 32'd1) ? '0 : i_q + 1'b1;
    assign i_plus_m  = 32'(i_q) + M;
    assign addr_m    = A_WIDTH'((i_plus_m >= N) ? i_plus_m - N : i_plus_m);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        prime_ph_d  = prime_ph_q;
        auto_d      = 1'b0;
        busy_d      = busy_q;
        ready_gen_d = ready_gen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        en0         = 1'b0;
        we0         = 1'b0;
        addr0       = '0;
        wdata0      = '0;
        en1         = 1'b0;
        addr1       = '0;

        // A new seed takes priority in every state and discards any pending word
        if (start) begin
            state_d     = INIT;
            i_d         = '0;
            prev_d      = start_val;
            prime_ph_d  = 1'b0;
            busy_d      = 1'b1;
            ready_gen_d = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                INIT: begin
                    en0    = 1'b1;
                    we0    = 1'b1;
                    addr0  = i_q;
                    wdata0 = init_val;
                    prev_d = init_val;
                    if (32'(i_q) == N - 32'd1) begin
                        state_d = PRIME;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                PRIME: begin
                    if (!prime_ph_q) begin
                        en0        = 1'b1;
                        addr0      = '0;
                        prime_ph_d = 1'b1;
                    end else begin
                        cur_d       = rdata0;
                        i_d         = '0;
                        prime_ph_d  = 1'b0;
                        busy_d      = 1'b0;
                        ready_gen_d = 1'b1;
                        state_d     = GEN_RD;
                    end
                end
                GEN_RD: begin
                    if (!(out_valid_q && !out_ready)) begin
                        en0         = 1'b1;
                        addr0       = i_plus1;
                        en1         = 1'b1;
                        addr1       = addr_m;
                        out_valid_d = 1'b0;
                        state_d     = GEN_WR;
                    end
                end
                GEN_WR: begin
                    en0         = 1'b1;
                    we0         = 1'b1;
                    addr0       = i_q;
                    wdata0      = new_word;
                    cur_d       = rdata0;
                    out_data_d  = tempered;
                    out_valid_d = 1'b1;
                    i_d         = i_plus1;
                    state_d     = GEN_RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            prime_ph_q  <= 1'b0;
            auto_q      <= AUTO_SEED;
            busy_q      <= 1'b0;
            ready_gen_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            prime_ph_q  <= prime_ph_d;
            auto_q      <= auto_d;
            busy_q      <= busy_d;
            ready_gen_q <= ready_gen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign ready_gen = ready_gen_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mt32_engine.sv
// tb/tb_mt32_engine.sv - randomized bench for mt32_engine against a batch-twist MT19937 model
`timescale 1ns/1ps
module tb_mt32_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed;
    logic        seed_valid;
    logic        busy, ready_gen, out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    logic        rst_a;
    logic [31:0] seed_a = 32'd0;
    logic        seed_valid_a = 1'b0;
    logic        busy_a, ready_gen_a, out_valid_a;
    logic [31:0] out_data_a;
    logic        out_ready_a = 1'b1;

    always #5 clk = ~clk;

    mt32_engine #(.AUTO_SEED(1'b0), .DEF_SEED(32'd5489), .A_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
        .busy(busy), .ready_gen(ready_gen), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mt32_engine #(.AUTO_SEED(1'b1), .DEF_SEED(32'd5489), .A_WIDTH(10)) dut_auto (
        .clk(clk), .rst(rst_a), .seed(seed_a), .seed_valid(seed_valid_a),
        .busy(busy_a), .ready_gen(ready_gen_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        held     = 1'b0;
    logic [31:0] held_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    logic [31:0] mdl [624];
    int          mdl_i;

    task automatic model_seed(input logic [31:0] s);
        mdl[0] = s;
        for (int k = 1; k < 624; k++)
            mdl[k] = 32'd1812433253 * (mdl[k-1] ^ (mdl[k-1] >> 30)) + 32'(k);
        mdl_i = 624;
    endtask

    task automatic model_next(output logic [31:0] w);
        logic [31:0] v;
        if (mdl_i >= 624) begin
            for (int k = 0; k < 624; k++) begin
                v = (mdl[k] & 32'h8000_0000) | (mdl[(k + 1) % 624] & 32'h7FFF_FFFF);
                mdl[k] = mdl[(k + 397) % 624] ^ (v >> 1) ^ (v[0] ? 32'h9908_B0DF : 32'd0);
            end
            mdl_i = 0;
        end
        v = mdl[mdl_i];
        mdl_i++;
        v = v ^ (v >> 11);
        v = v ^ ((v << 7) & 32'h9D2C_5680);
        v = v ^ ((v << 15) & 32'hEFC6_0000);
        w = v ^ (v >> 18);
    endtask

    task automatic get_one(input bit rnd, output logic [31:0] w);
        bit got = 1'b0;
        w = '0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (held) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, held_data);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                w    = out_data;
                got  = 1'b1;
                held = 1'b0;
            end else begin
                held      = out_valid && !out_ready;
                held_data = out_data;
            end
        end
        if (!got) check("word_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic take_model(input int n, input bit rnd, input string tag);
        logic [31:0] w, e;
        for (int k = 0; k < n; k++) begin
            get_one(rnd, w);
            model_next(e);
            check(tag, w, e);
        end
    endtask

    task automatic do_seed(input logic [31:0] s);
        @(negedge clk);
        out_ready  = 1'b0;
        seed       = s;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        held       = 1'b0;
    endtask

    initial begin
        logic [31:0] w, e;
        time         t0, t1;
        int          cnt;

        rst = 1'b1; rst_a = 1'b1; seed = '0; seed_valid = 1'b0; out_ready = 1'b0;
        t0 = 0; t1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready_gen", {31'd0, ready_gen}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // seed 5489, ready held high: fixed prefix, 1000-word stream, throughput
        do_seed(32'd5489);
        model_seed(32'd5489);
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cnt), 32'd626);
        check("ready_gen_up", {31'd0, ready_gen}, 32'd1);
        get_one(1'b0, w); model_next(e); check("seq5489_0", w, 32'd3499211612);
        get_one(1'b0, w); model_next(e); check("seq5489_1", w, 32'd581869302);
        get_one(1'b0, w); model_next(e); check("seq5489_2", w, 32'd3890346734);
        for (int k = 3; k < 1000; k++) begin
            get_one(1'b0, w);
            model_next(e);
            check("seq5489", w, e);
            if (k == 10)  t0 = $time;
            if (k == 110) t1 = $time;
        end
        check("throughput_cycles", 32'((t1 - t0) / 10), 32'd200);

        // randomly stalled consumer
        take_model(300, 1'b1, "rand_ready");

        // reseed mid-generation, then abort with seed=1 after 50 words
        do_seed(32'd5489);
        model_seed(32'd5489);
        take_model(50, 1'b1, "reseed5489");
        do_seed(32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_ready_gen", {31'd0, ready_gen}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        model_seed(32'd1);
        get_one(1'b1, w); model_next(e); check("seq1_0", w, 32'd1791095845);
        take_model(20, 1'b1, "seq1");

        // reset in the middle of INIT, then a clean reseed
        do_seed(32'd777);
        repeat (299) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready_gen", {31'd0, ready_gen}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        rst = 1'b0;
        do_seed(32'd5489);
        model_seed(32'd5489);
        get_one(1'b0, w); model_next(e); check("after_rst_0", w, 32'd3499211612);
        take_model(10, 1'b1, "after_rst");

        // auto-seed instance: reset release alone starts the stream
        @(negedge clk);
        rst_a = 1'b0;
        cnt = 0;
        while (!out_valid_a && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("auto_valid", {31'd0, out_valid_a}, 32'd1);
        check("auto_first", out_data_a, 32'd3499211612);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
